id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_if.sv | 54 +++++
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decode-slot inputs, forwarding sources, pipeline controls,
// and the registered execute-side outputs.
// Latency: n/a (wiring only). Backpressure: ex_hold in, stall out.
interface id_ex_if #(
  parameter int CTRL_W = 8
);
  // decode slot
  logic              id_valid;
  logic [2:0]        id_rs1;
  logic [2:0]        id_rs2;
  logic [2:0]        id_rd;
  logic [15:0]       BusA;
  logic [15:0]       BusB;
  logic [15:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  // forwarding sources
  logic [15:0]       ex_result;
  logic [2:0]        mem_rd;
  logic              mem_reg_write;
  logic [15:0]       mem_result;
  logic [2:0]        wb_rd;
  logic              wb_reg_write;
  logic [15:0]       wb_data;
  // pipeline control
  logic              flush;
  logic              ex_hold;
  logic              stall;
  // execute-side registers
  logic              ex_valid_o;
  logic [15:0]       ex_op_a;
  logic [15:0]       ex_op_b;
  logic [15:0]       ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [2:0]        ex_rd_o;
  logic [15:0]       stall_count;

  // master: decode / hazard side that drives the stage
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, BusA, BusB, id_imm, id_ctrl,
    output ex_result, mem_rd, mem_reg_write, mem_result,
    output wb_rd, wb_reg_write, wb_data, flush, ex_hold,
    input  stall, ex_valid_o, ex_op_a, ex_op_b, ex_imm_o, ex_ctrl_o, ex_rd_o,
    input  stall_count
  );

  // slave: the ID/EX register stage itself
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, BusA, BusB, id_imm, id_ctrl,
    input  ex_result, mem_rd, mem_reg_write, mem_result,
    input  wb_rd, wb_reg_write, wb_data, flush, ex_hold,
    output stall, ex_valid_o, ex_op_a, ex_op_b, ex_imm_o, ex_ctrl_o, ex_rd_o,
    output stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM/WB operand forwarding and load-use hazard bubble.
// Latency: one clock from decode slot to ex_* outputs; stall is combinational.
// Backpressure: ex_hold freezes every output register; stall asks upstream to freeze PC and IF/ID.
// Ports: clk, rst_n (async, active-low), bus (id_ex_if.slave; ctrl bit0 = reg_write, bit1 = mem_read).
module id_ex_stage #(
  parameter int CTRL_W = 8
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  logic              ex_fwd_en;
  logic              load_use;
  logic              stall_i;
  logic [15:0]       op_a_sel;
  logic [15:0]       op_b_sel;
  logic [CTRL_W-1:0] ctrl_nxt;

  // First match wins: R0, then youngest producer (EX), then MEM, then WB, then register file.
  function automatic logic [15:0] pick_operand(
    input logic [2:0]  rs,
    input logic [15:0] rf_dat,
    input logic        ex_en,
    input logic [2:0]  ex_rd,
    input logic [15:0] ex_dat,
    input logic        mem_en,
    input logic [2:0]  mem_rd,
    input logic [15:0] mem_dat,
    input logic        wb_en,
    input logic [2:0]  wb_rd,
    input logic [15:0] wb_dat
  );
    logic [15:0] res;
    if (rs == 3'd0)                    res = 16'h0000;
    else if (ex_en  && ex_rd  == rs)   res = ex_dat;
    else if (mem_en && mem_rd == rs)   res = mem_dat;
    else if (wb_en  && wb_rd  == rs)   res = wb_dat;
    else                               res = rf_dat;
    return res;
  endfunction

  // A load in EX has no result yet, so it must not forward; it triggers load_use instead.
  assign ex_fwd_en = bus.ex_valid_o & bus.ex_ctrl_o[0] & ~bus.ex_ctrl_o[1];

  assign load_use = bus.id_valid & bus.ex_valid_o & bus.ex_ctrl_o[1] &
                    (bus.ex_rd_o != 3'd0) &
                    ((bus.ex_rd_o == bus.id_rs1) | (bus.ex_rd_o == bus.id_rs2));

  // A flush overrides any freeze request: the entering instruction is dead anyway.
  assign stall_i   = ~bus.flush & (bus.ex_hold | load_use);
  assign bus.stall = stall_i;

  assign op_a_sel = pick_operand(bus.id_rs1, bus.BusA, ex_fwd_en, bus.ex_rd_o, bus.ex_result,
                                 bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                                 bus.wb_reg_write, bus.wb_rd, bus.wb_data);
  assign op_b_sel = pick_operand(bus.id_rs2, bus.BusB, ex_fwd_en, bus.ex_rd_o, bus.ex_result,
                                 bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                                 bus.wb_reg_write, bus.wb_rd, bus.wb_data);

  assign ctrl_nxt = bus.id_valid ? bus.id_ctrl : {CTRL_W{1'b0}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid_o  <= 1'b0;
      bus.ex_op_a     <= 16'h0000;
      bus.ex_op_b     <= 16'h0000;
      bus.ex_imm_o    <= 16'h0000;
      bus.ex_ctrl_o   <= {CTRL_W{1'b0}};
      bus.ex_rd_o     <= 3'd0;
      bus.stall_count <= 16'h0000;
    end else begin
      // Saturating counter of stalled cycles.
      if (stall_i && bus.stall_count != 16'hFFFF) begin
        bus.stall_count <= bus.stall_count + 16'h0001;
      end

      if (bus.flush) begin
        // Operand registers keep their (don't-care) contents.
        bus.ex_valid_o <= 1'b0;
        bus.ex_ctrl_o  <= {CTRL_W{1'b0}};
        bus.ex_rd_o    <= 3'd0;
      end else if (bus.ex_hold) begin
        // Downstream busy: hold everything.
      end else if (load_use) begin
        // Bubble for one cycle; next cycle the load sits in MEM and forwards from there.
        bus.ex_valid_o <= 1'b0;
        bus.ex_ctrl_o  <= {CTRL_W{1'b0}};
        bus.ex_rd_o    <= 3'd0;
      end else begin
        bus.ex_valid_o <= bus.id_valid;
        bus.ex_op_a    <= op_a_sel;
        bus.ex_op_b    <= op_b_sel;
        bus.ex_imm_o   <= bus.id_imm;
        bus.ex_ctrl_o  <= ctrl_nxt;
        bus.ex_rd_o    <= bus.id_rd;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a sequential step table (inputs, expected stall
// before the edge, expected registers after the edge) plus hand-written reset sequences.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;

  id_ex_if #(.CTRL_W(8)) bus ();

  id_ex_stage #(.CTRL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id_valid; int rs1; int rs2; int rd;
    int busa; int busb; int imm; int ctrl; int ex_result;
    int mem_rw; int mem_rd; int mem_result;
    int wb_rw; int wb_rd; int wb_data;
    int flush; int hold;
    // expectations
    int x_stall; int chk_ops; int x_valid;
    int x_a; int x_b; int x_imm; int x_ctrl; int x_rd; int x_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid      = v.id_valid[0];
    bus.id_rs1        = v.rs1[2:0];
    bus.id_rs2        = v.rs2[2:0];
    bus.id_rd         = v.rd[2:0];
    bus.BusA          = v.busa[15:0];
    bus.BusB          = v.busb[15:0];
    bus.id_imm        = v.imm[15:0];
    bus.id_ctrl       = v.ctrl[7:0];
    bus.ex_result     = v.ex_result[15:0];
    bus.mem_reg_write = v.mem_rw[0];
    bus.mem_rd        = v.mem_rd[2:0];
    bus.mem_result    = v.mem_result[15:0];
    bus.wb_reg_write  = v.wb_rw[0];
    bus.wb_rd         = v.wb_rd[2:0];
    bus.wb_data       = v.wb_data[15:0];
    bus.flush         = v.flush[0];
    bus.ex_hold       = v.hold[0];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, int'(bus.ex_valid_o), 0);
    chk({tag, ".op_a"},  int'(bus.ex_op_a), 0);
    chk({tag, ".op_b"},  int'(bus.ex_op_b), 0);
    chk({tag, ".imm"},   int'(bus.ex_imm_o), 0);
    chk({tag, ".ctrl"},  int'(bus.ex_ctrl_o), 0);
    chk({tag, ".rd"},    int'(bus.ex_rd_o), 0);
    chk({tag, ".cnt"},   int'(bus.stall_count), 0);
    chk({tag, ".stall"}, int'(bus.stall), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    // Field order: id_valid rs1 rs2 rd busa busb imm ctrl ex_result | mem_rw mem_rd mem_result |
    //              wb_rw wb_rd wb_data | flush hold || x_stall chk_ops x_valid x_a x_b x_imm x_ctrl x_rd x_cnt
    // s0: plain capture, nothing to forward
    vecs.push_back('{1,1,2,3,'h0010,'h0020,'h0005,'h01,'h0000, 0,0,0, 0,0,0, 0,0,  0,1,1,'h0010,'h0020,'h0005,'h01,3,0});
    // s1: EX forward of rd3 onto rs1
    vecs.push_back('{1,3,0,5,'h0000,'h1234,'h0007,'h01,'h00AB, 0,0,0, 0,0,0, 0,0,  0,1,1,'h00AB,'h0000,'h0007,'h01,5,0});
    // s2: EX/MEM/WB all write r5 -> EX wins on rs2
    vecs.push_back('{1,1,5,5,'h0001,'h0BBB,'h0000,'h00,'h1111, 1,5,'h2222, 1,5,'h3333, 0,0,  0,1,1,'h0001,'h1111,'h0000,'h00,5,0});
    // s3: EX holds r5 but does not write -> MEM wins; rs1=0 forces zero
    vecs.push_back('{1,0,5,7,'h5555,'h0BBB,'h0000,'h01,'h1111, 1,5,'h2222, 1,5,'h3333, 0,0,  0,1,1,'h0000,'h2222,'h0000,'h01,7,0});
    // s4: only WB writes r5; rs1 takes EX forward of r7; issue load to r4
    vecs.push_back('{1,7,5,4,'h0AAA,'h0BBB,'h0010,'h03,'h7777, 0,5,'h2222, 1,5,'h3333, 0,0,  0,1,1,'h7777,'h3333,'h0010,'h03,4,0});
    // s5: load-use on rs1 -> stall, bubble
    vecs.push_back('{1,4,0,2,'h9999,'h0000,'h0001,'h01,'h0000, 0,0,0, 0,0,0, 0,0,  1,0,0,0,0,0,'h00,0,1});
    // s6: load now in MEM -> forwarded
    vecs.push_back('{1,4,0,2,'h9999,'h0000,'h0001,'h01,'h0000, 1,4,'h0042, 0,0,0, 0,0,  0,1,1,'h0042,'h0000,'h0001,'h01,2,1});
    // s7: R0 ignores WB write to r0; issue load to r3
    vecs.push_back('{1,0,3,3,'h1234,'h0033,'h0000,'h03,'h0000, 0,0,0, 1,0,'hFFFF, 0,0,  0,1,1,'h0000,'h0033,'h0000,'h03,3,1});
    // s8: flush with hold and load_use -> no stall, count unchanged
    vecs.push_back('{1,3,0,1,'h4444,'h0000,'h0000,'h01,'h0000, 0,0,0, 0,0,0, 1,1,  0,0,0,0,0,0,'h00,0,1});
    // s9: fresh capture, ctrl bit7 passes through
    vecs.push_back('{1,1,2,5,'h00A1,'h00B2,'h00C3,'h81,'h0000, 0,0,0, 0,0,0, 0,0,  0,1,1,'h00A1,'h00B2,'h00C3,'h81,5,1});
    // s10-s13: ex_hold for 4 cycles -> frozen, count +4
    for (int k = 0; k < 4; k++)
      vecs.push_back('{1,6,6,6,'hDEAD,'hBEEF,'h0F0F,'h02,'h0000, 0,0,0, 0,0,0, 0,1,  1,1,1,'h00A1,'h00B2,'h00C3,'h81,5,2+k});
    // s14: id_valid=0 -> ctrl cleared, valid 0
    vecs.push_back('{0,1,2,1,'h0101,'h0202,'h0303,'hFF,'h0000, 0,0,0, 0,0,0, 0,0,  0,1,0,'h0101,'h0202,'h0303,'h00,1,5});
    // s15: invalid slot held (rd1) does not forward
    vecs.push_back('{1,1,0,1,'h0202,'h0000,'h0000,'h02,'hEEEE, 0,0,0, 0,0,0, 0,0,  0,1,1,'h0202,'h0000,'h0000,'h02,1,5});
    // s16: load in EX but id_valid=0 -> no load_use; load does not forward
    vecs.push_back('{0,1,0,0,'h0303,'h0000,'h0000,'h03,'hEEEE, 0,0,0, 0,0,0, 0,0,  0,1,0,'h0303,'h0000,'h0000,'h00,0,5});
    // s17: issue load to r2
    vecs.push_back('{1,0,0,2,'h0000,'h0000,'h0000,'h03,'h0000, 0,0,0, 0,0,0, 0,0,  0,1,1,'h0000,'h0000,'h0000,'h03,2,5});
    // s18: load-use on rs2
    vecs.push_back('{1,0,2,3,'h0000,'h5A5A,'h0000,'h01,'h0000, 0,0,0, 0,0,0, 0,0,  1,0,0,0,0,0,'h00,0,6});
    // s19: MEM forward of r2 onto rs2
    vecs.push_back('{1,0,2,3,'h0000,'h5A5A,'h0000,'h01,'h0000, 1,2,'h0ABC, 0,0,0, 0,0,  0,1,1,'h0000,'h0ABC,'h0000,'h01,3,6});
    // s20: load targeting r0
    vecs.push_back('{1,0,0,0,'h0000,'h0000,'h0000,'h03,'h0000, 0,0,0, 0,0,0, 0,0,  0,1,1,'h0000,'h0000,'h0000,'h03,0,6});
    // s21: load to r0 never causes load_use
    vecs.push_back('{1,0,0,1,'h0000,'h0000,'h0000,'h01,'h0000, 0,0,0, 0,0,0, 0,0,  0,1,1,'h0000,'h0000,'h0000,'h01,1,6});

    // Reset with all inputs idle.
    z = '{default: 0};
    rst_n = 1'b0;
    drive(z);
    #3;
    chk_all_zero("reset");
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("s%0d.stall", i), int'(bus.stall), vecs[i].x_stall);
      @(posedge clk);
      #1;
      chk($sformatf("s%0d.valid", i), int'(bus.ex_valid_o), vecs[i].x_valid);
      chk($sformatf("s%0d.ctrl", i),  int'(bus.ex_ctrl_o),  vecs[i].x_ctrl);
      chk($sformatf("s%0d.rd", i),    int'(bus.ex_rd_o),    vecs[i].x_rd);
      chk($sformatf("s%0d.cnt", i),   int'(bus.stall_count), vecs[i].x_cnt);
      if (vecs[i].chk_ops != 0) begin
        chk($sformatf("s%0d.op_a", i), int'(bus.ex_op_a),  vecs[i].x_a);
        chk($sformatf("s%0d.op_b", i), int'(bus.ex_op_b),  vecs[i].x_b);
        chk($sformatf("s%0d.imm", i),  int'(bus.ex_imm_o), vecs[i].x_imm);
      end
    end

    // Mid-operation async reset: valid instr held, stall_count = 6; reset between edges.
    drive(z);
    bus.id_valid = 1'b1;
    bus.id_rs1   = 3'd1;
    bus.id_rd    = 3'd2;
    bus.BusA     = 16'h00AB;
    bus.id_imm   = 16'h0005;
    bus.id_ctrl  = 8'h01;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    // Held in reset across an edge: still nothing captured.
    @(posedge clk);
    #1;
    chk("rst_hold.valid", int'(bus.ex_valid_o), 0);
    chk("rst_hold.op_a",  int'(bus.ex_op_a), 0);
    chk("rst_hold.stall", int'(bus.stall), 0);
    // Release between edges: no capture until the next rising edge.
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_rel.valid", int'(bus.ex_valid_o), 0);
    @(posedge clk);
    #1;
    chk("first_cap.valid", int'(bus.ex_valid_o), 1);
    chk("first_cap.op_a",  int'(bus.ex_op_a), 'h00AB);
    chk("first_cap.imm",   int'(bus.ex_imm_o), 'h0005);
    chk("first_cap.rd",    int'(bus.ex_rd_o), 2);
    chk("first_cap.cnt",   int'(bus.stall_count), 0);
    // No combinational path from id_* to the registered outputs.
    bus.BusA     = 16'h1111;
    bus.id_valid = 1'b0;
    #2;
    chk("no_comb.op_a",  int'(bus.ex_op_a), 'h00AB);
    chk("no_comb.valid", int'(bus.ex_valid_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
